// File: rtl/vedic_pkg.sv
// Shared types and width helpers for the Vedic multiply/divide datapath.
// The state encoding is fixed so traces can be read directly.
package vedic_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned dw_of(input int unsigned n);
        return 2 * n;
    endfunction

    function automatic int unsigned cw_of(input int unsigned n);
        return $clog2(2 * n) + 1;
    endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, built as a ripple of full adders on the inverted divisor.
module div_sub_step #(
    parameter int unsigned N = 4
) (
    input  logic [N:0]   rem,
    input  logic [N-1:0] div,
    output logic [N-1:0] rem_next,
    output logic         q_bit
);

    logic [N-1:0] div_inv;
    logic [N-1:0] diff;
    logic [N:0]   carry;

    assign div_inv  = ~div;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < N; i++) begin : g_fa
        assign diff[i]      = rem[i] ^ div_inv[i] ^ carry[i];
        assign carry[i + 1] = (rem[i] & div_inv[i]) | (carry[i] & (rem[i] ^ div_inv[i]));
    end

    // Top bit of the padded divisor is 0 (inverted: 1), so the final stage
    // reduces to an OR. Carry-out set means no borrow.
    assign q_bit = rem[N] | carry[N];

    // A clear q_bit implies rem < div < 2^N, so rem's low N bits are the
    // restored value.
    assign rem_next = q_bit ? diff : rem[N-1:0];

endmodule

// File: rtl/vedic_div_seq.sv
// Sequential unsigned restoring divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, MSB first, with valid/ready on both sides.
module vedic_div_seq
    import vedic_pkg::*;
#(
    parameter int unsigned  N  = 4,
    localparam int unsigned DW = dw_of(N),
    localparam int unsigned CW = cw_of(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [N-1:0]  divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [N-1:0]  remainder,
    output logic          div_by_zero
);

    state_e        state_q, state_d;
    logic [DW-1:0] q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [N-1:0]  r_q, r_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;

    logic [N:0]   r_shift;
    logic [N-1:0] step_rem;
    logic         step_q;

    // Stored remainder is always below the divisor, so N bits suffice; the
    // shifted trial value needs one extra.
    assign r_shift = {r_q, q_q[DW-1]};

    div_sub_step #(
        .N(N)
    ) u_step (
        .rem      (r_shift),
        .div      (d_q),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    d_d   = divisor;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        q_d     = '1;
                        r_d     = dividend[N-1:0];
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        q_d     = dividend;
                        r_d     = '0;
                        dbz_d   = 1'b0;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                q_d   = {q_q[DW-2:0], step_q};
                r_d   = step_rem;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = (state_q == StDone);
    assign quotient    = q_q;
    assign remainder   = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_vedic_div_seq.sv
// Self-checking bench for vedic_div_seq (N=4): directed cases, backpressure,
// mid-operation reset and a randomised stream against an arithmetic model.
module tb_vedic_div_seq;

    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    vedic_div_seq #(
        .N(N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference: plain / and %, with the divide-by-zero convention.
    task automatic ref_div(input logic [7:0] a, input logic [3:0] b,
                           output logic [7:0] q, output logic [3:0] r, output logic z);
        if (b == 0) begin
            q = 8'hFF;
            r = a[3:0];
            z = 1'b1;
        end else begin
            q = 8'(int'(a) / int'(b));
            r = 4'(int'(a) % int'(b));
            z = 1'b0;
        end
    endtask

    // Accepts one operand pair; lat counts edges from the accept edge (inclusive)
    // until out_valid is seen.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] a, input logic [3:0] b);
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        ref_div(a, b, eq, er, ez);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rel_ready"}, 32'(in_ready), 32'd1);
    endtask

    logic [7:0] dir_a [5] = '{8'd200, 8'd255, 8'd100, 8'd0, 8'h3F};
    logic [3:0] dir_b [5] = '{4'd7, 4'd15, 4'd1, 4'd5, 4'd0};

    initial begin
        int         lat;
        int         acc;
        int         got;
        int         cyc;
        logic       acc_now;
        logic [11:0] pend[$];
        logic [11:0] e;
        logic [7:0] eq;
        logic [3:0] er;
        logic       ez;
        int unsigned iq, ir, ia, ib;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);

        // Directed cases, including divisor=1, zero dividend and divide by zero.
        for (int i = 0; i < 5; i++) begin
            run_op(dir_a[i], dir_b[i], lat);
            check($sformatf("dir%0d_lat", i), 32'(lat), (dir_b[i] == 0) ? 32'd1 : 32'd9);
            check_result($sformatf("dir%0d", i), dir_a[i], dir_b[i]);
            release_result($sformatf("dir%0d", i));
        end
        run_op(8'd200, 4'd7, lat);
        check("lit_200_7_q", 32'(quotient), 32'd28);
        check("lit_200_7_r", 32'(remainder), 32'd4);

        // Backpressure: result held, new requests ignored.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            dividend = 8'd9;
            divisor  = 4'd3;
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_q", 32'(quotient), 32'd28);
            check("bp_r", 32'(remainder), 32'd4);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_result("bp");

        // Reset during the 4th CALC cycle discards the operation.
        in_valid = 1'b1;
        dividend = 8'd200;
        divisor  = 4'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_q", 32'(quotient), 32'd0);
        check("mrst_r", 32'(remainder), 32'd0);
        check("mrst_dbz", 32'(div_by_zero), 32'd0);
        run_op(8'd9, 4'd3, lat);
        check("mrst_after_lat", 32'(lat), 32'd9);
        check_result("mrst_after", 8'd9, 4'd3);
        release_result("mrst_after");

        // Randomised stream with random input gaps and output backpressure.
        acc       = 0;
        got       = 0;
        cyc       = 0;
        in_valid  = 1'b1;
        dividend  = 8'($urandom_range(0, 255));
        divisor   = 4'($urandom_range(0, 15));
        out_ready = ($urandom_range(0, 2) != 0);
        while ((acc < 1000 || got < acc) && cyc < 40000) begin
            @(negedge clk);
            acc_now = in_valid && in_ready;
            if (acc_now) begin
                pend.push_back({dividend, divisor});
                acc++;
            end
            if (out_valid && out_ready) begin
                if (pend.size() == 0) begin
                    check("rand_extra_result", 32'd1, 32'd0);
                end else begin
                    e = pend.pop_front();
                    ref_div(e[11:4], e[3:0], eq, er, ez);
                    check("rand_q", 32'(quotient), 32'(eq));
                    check("rand_r", 32'(remainder), 32'(er));
                    check("rand_dbz", 32'(div_by_zero), 32'(ez));
                    if (e[3:0] != 0) begin
                        iq = 32'(quotient);
                        ir = 32'(remainder);
                        ia = 32'(e[11:4]);
                        ib = 32'(e[3:0]);
                        check("rand_inv", 32'((iq * ib + ir == ia) && (ir < ib)), 32'd1);
                    end
                end
                got++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (acc_now || !in_valid) begin
                if (acc < 1000) begin
                    in_valid = ($urandom_range(0, 3) != 0);
                    dividend = 8'($urandom_range(0, 255));
                    divisor  = 4'($urandom_range(0, 15));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 2) != 0);
        end
        check("rand_results", 32'(got), 32'd1000);
        check("rand_pending", 32'(pend.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
